i2s_tx_stereo: RTL

Parametrised stereo I2S transmitter with an input frame FIFO. It generates `sck`, `ws` and `sd` from the system clock and serialises left/right samples MSB-first in Philips I2S format, with `ws` leading data by one bit. Upstream logic supplies stereo frames through a ready/valid handshake. The block sits between the audio sample source and the DAC pins, and generalises the single-word 8-bit controller to configurable sample width, slot width and buffering.

---
 rtl/i2s_tx_stereo_if.sv | 12 +
 rtl/i2s_tx_stereo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_stereo_if.sv
// Stereo frame handshake between the sample source and the I2S transmitter.
interface i2s_tx_stereo_if #(
    parameter int BITS = 16
);
    logic            i_valid;
    logic            i_ready;
    logic [BITS-1:0] i_left;
    logic [BITS-1:0] i_right;

    modport master (output i_valid, i_left, i_right, input i_ready);
    modport slave  (input i_valid, i_left, i_right, output i_ready);
endinterface

// File: rtl/i2s_tx_stereo.sv
// Philips I2S stereo transmitter with a frame FIFO; ws leads data by one bit.
// Optional feature: I2S_TX_UNDERFLOW_REPEAT_EN retransmits the previous frame on underflow.
module i2s_tx_stereo #(
    parameter int CLK_HZ        = 12_000_000,
    parameter int I2S_CLK_HZ    = 400_000,
    parameter int DIVIDER_COUNT = CLK_HZ / I2S_CLK_HZ / 2,
    parameter int BITS          = 16,
    parameter int SLOT_BITS     = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    i2s_tx_stereo_if.slave              bus,
    output logic                        sck,
    output logic                        ws,
    output logic                        sd,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underflow,
    input  logic                        clear_underflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = $clog2(DIVIDER_COUNT + 1);
    localparam int PW = $clog2(2 * SLOT_BITS);
    localparam logic [DW-1:0] DIV_RELOAD = DW'(DIVIDER_COUNT - 1);
    localparam logic [PW-1:0] P_LAST     = PW'(2 * SLOT_BITS - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_reg, state_next;
    logic [DW-1:0]     div_reg, div_next;
    logic              sck_reg, sck_next;
    logic              ws_reg, ws_next;
    logic              sd_reg, sd_next;
    logic              stop_reg, stop_next;
    logic [PW-1:0]     p_reg, p_next;
    logic [BITS-1:0]   left_reg, left_next;
    logic [BITS-1:0]   right_reg, right_next;
    logic              underflow_reg, underflow_next;

    logic [2*BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]     level_reg, level_next;
    logic              ready_reg;

    logic              push, pop, fall, uf_set, fifo_empty, right_ch;
    logic [2*BITS-1:0] head;
    logic [BITS-1:0]   tx_word, shifted;
    int unsigned       p_int, pos;

    assign push       = bus.i_valid && ready_reg;
    assign fifo_empty = (level_reg == '0);
    assign head       = mem[rd_ptr_reg];

    always_comb begin
        state_next     = state_reg;
        div_next       = div_reg;
        sck_next       = sck_reg;
        ws_next        = ws_reg;
        sd_next        = sd_reg;
        stop_next      = stop_reg;
        p_next         = p_reg;
        left_next      = left_reg;
        right_next     = right_reg;
        pop            = 1'b0;
        uf_set         = 1'b0;
        fall           = 1'b0;
        right_ch       = 1'b0;
        p_int          = 0;
        pos            = 0;
        tx_word        = '0;
        shifted        = '0;

        unique case (state_reg)
            IDLE: begin
                sck_next  = 1'b0;
                ws_next   = 1'b0;
                sd_next   = 1'b0;
                div_next  = DIV_RELOAD;
                p_next    = '0;
                stop_next = 1'b0;
                if (enable)
                    state_next = RUN;
            end
            RUN: begin
                if (div_reg != '0) begin
                    div_next = div_reg - 1'b1;
                end else begin
                    div_next = DIV_RELOAD;
                    if (!sck_reg) begin
                        // A pending stop replaces the rising edge after the last bit.
                        if (stop_reg) begin
                            state_next = IDLE;
                            stop_next  = 1'b0;
                            ws_next    = 1'b0;
                            sd_next    = 1'b0;
                            p_next     = '0;
                        end else begin
                            sck_next = 1'b1;
                        end
                    end else begin
                        sck_next = 1'b0;
                        fall     = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (fall) begin
            if (p_reg == '0) begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    left_next  = head[2*BITS-1:BITS];
                    right_next = head[BITS-1:0];
                end else begin
                    uf_set = 1'b1;
`ifndef I2S_TX_UNDERFLOW_REPEAT_EN
                    left_next  = '0;
                    right_next = '0;
`endif
                end
            end
            p_int    = 32'(p_reg);
            right_ch = (p_int >= SLOT_BITS);
            pos      = right_ch ? p_int - SLOT_BITS : p_int;
            tx_word  = right_ch ? right_next : left_next;
            shifted  = tx_word >> (BITS - 1 - pos);
            // Slot bits beyond the sample width are padded with zeros.
            sd_next  = (pos < BITS) && shifted[0];
            ws_next  = (p_int >= SLOT_BITS - 1) && (p_int <= 2 * SLOT_BITS - 2);
            p_next   = (p_reg == P_LAST) ? '0 : p_reg + 1'b1;
            if (p_reg == P_LAST && !enable)
                stop_next = 1'b1;
        end

        unique case ({push, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase

        // A new underflow in the same cycle as a clear keeps the flag set.
        if (uf_set)
            underflow_next = 1'b1;
        else if (clear_underflow)
            underflow_next = 1'b0;
        else
            underflow_next = underflow_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            div_reg       <= DIV_RELOAD;
            sck_reg       <= 1'b0;
            ws_reg        <= 1'b0;
            sd_reg        <= 1'b0;
            stop_reg      <= 1'b0;
            p_reg         <= '0;
            left_reg      <= '0;
            right_reg     <= '0;
            underflow_reg <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            ready_reg     <= 1'b1;
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_next;
            sck_reg       <= sck_next;
            ws_reg        <= ws_next;
            sd_reg        <= sd_next;
            stop_reg      <= stop_next;
            p_reg         <= p_next;
            left_reg      <= left_next;
            right_reg     <= right_next;
            underflow_reg <= underflow_next;
            level_reg     <= level_next;
            ready_reg     <= (level_next != LEVEL_FULL);
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= {bus.i_left, bus.i_right};
    end

    assign bus.i_ready = ready_reg;
    assign sck         = sck_reg;
    assign ws          = ws_reg;
    assign sd          = sd_reg;
    assign fifo_level  = level_reg;
    assign underflow   = underflow_reg;
endmodule
